// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and a bit-count helper also
// used to size the receiver's oversampling counter.
package uart_pkg;

    typedef enum logic [3:0] {
        TX_IDLE  = 4'b0000,
        TX_START = 4'b0100,
        TX_BIT0  = 4'b1000,
        TX_BIT1  = 4'b1001,
        TX_BIT2  = 4'b1010,
        TX_BIT3  = 4'b1011,
        TX_BIT4  = 4'b1100,
        TX_BIT5  = 4'b1101,
        TX_BIT6  = 4'b1110,
        TX_BIT7  = 4'b1111,
        TX_STOP1 = 4'b0010,
        TX_STOP2 = 4'b0011
    } tx_state_e;

    // Number of bits needed to hold v (0 for v == 0).
    function automatic int unsigned log2(input int unsigned v);
        int unsigned n;
        n = 0;
        while ((v >> n) != 0) n++;
        return n;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Phase-accumulator tick generator: one-cycle tick at Baud*Oversampling per second,
// taken from the accumulator carry-out. Held at zero while disabled.
module uart_baud_tick #(
    parameter int unsigned ClkFrequency = 25000000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned Oversampling = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);
    import uart_pkg::*;

`ifdef SIMULATION
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, enable};
    assign tick = 1'b1;
`else
    localparam int unsigned AccWidth = log2(ClkFrequency / Baud) + 8;
    localparam longint unsigned IncWide =
        ((longint'(Baud) * longint'(Oversampling) << AccWidth) + longint'(ClkFrequency / 2))
        / longint'(ClkFrequency);
    localparam logic [AccWidth:0] Inc = IncWide[AccWidth:0];

    logic [AccWidth:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            acc_q <= '0;
        end else begin
            acc_q <= {1'b0, acc_q[AccWidth-1:0]} + Inc;
        end
    end

    assign tick = acc_q[AccWidth];
`endif

endmodule

// File: rtl/async_transmitter.sv
// UART transmitter: accepts one byte per TxD_start while idle and sends it as an
// 8N1/8N2 frame, LSB first. TxD and TxD_busy come straight from flops.
module async_transmitter #(
    parameter int unsigned ClkFrequency = 25000000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned StopBits     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy
);
    import uart_pkg::*;

    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
        $error("async_transmitter: StopBits must be 1 or 2");
    end
    if (ClkFrequency < 2 * Baud) begin : g_bad_clk_ratio
        $error("async_transmitter: ClkFrequency must be at least 2*Baud");
    end

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       txd_d;
    logic       busy_d;
    logic       bit_tick;

    uart_baud_tick #(
        .ClkFrequency(ClkFrequency),
        .Baud        (Baud),
        .Oversampling(1)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(TxD_busy),
        .tick  (bit_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        case (state_q)
            TX_IDLE: begin
                if (TxD_start) begin
                    state_d = TX_START;
                    shift_d = TxD_data;
                end
            end
            TX_START: if (bit_tick) state_d = TX_BIT0;
            TX_BIT0, TX_BIT1, TX_BIT2, TX_BIT3, TX_BIT4, TX_BIT5, TX_BIT6: begin
                if (bit_tick) begin
                    state_d = tx_state_e'(state_q + 4'd1);
                    shift_d = shift_q >> 1;
                end
            end
            TX_BIT7: begin
                if (bit_tick) begin
                    state_d = TX_STOP1;
                    shift_d = shift_q >> 1;
                end
            end
            TX_STOP1: if (bit_tick) state_d = (StopBits == 2) ? TX_STOP2 : TX_IDLE;
            TX_STOP2: if (bit_tick) state_d = TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase

        // Line level is registered from the next state so it changes with the state.
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_BIT0, TX_BIT1, TX_BIT2, TX_BIT3,
            TX_BIT4, TX_BIT5, TX_BIT6, TX_BIT7: txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != TX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= TX_IDLE;
            shift_q  <= 8'h00;
            TxD      <= 1'b1;
            TxD_busy <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            TxD      <= txd_d;
            TxD_busy <= busy_d;
        end
    end

endmodule
